// File: rtl/uart_wb_bridge.sv
// UART command decoder acting as a Wishbone classic master: 'R'/'W' commands in, one bus cycle each, reply bytes out.
// Optional: define UART_WB_BRIDGE_RX_TIMEOUT_EN to discard partial commands after RX_TIMEOUT_CYCLES idle cycles.
module uart_wb_bridge #(
  parameter int unsigned WB_TIMEOUT_CYCLES = 1023,
  parameter int unsigned RX_TIMEOUT_CYCLES = 270000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic [31:0] wb_addr_o,
  output logic        wb_we_o,
  output logic [31:0] wb_data_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  localparam int unsigned WB_CNT_MIN = $clog2(WB_TIMEOUT_CYCLES + 1);
  localparam int unsigned WB_CNT_W   = (WB_CNT_MIN > 10) ? WB_CNT_MIN : 10;
  localparam logic [7:0]  CMD_READ   = 8'h52;
  localparam logic [7:0]  CMD_WRITE  = 8'h57;
  localparam logic [7:0]  RSP_ERR    = 8'h45;
  localparam logic [7:0]  RSP_OK     = 8'h4B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WB,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_we;
  logic [2:0]            r_idx;
  logic [WB_CNT_W-1:0]   r_wb_cnt;
  logic                  r_err;
  logic                  r_cyc;
  logic                  r_rx_ready;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_busy;

  logic w_rx_fire;
  logic w_tx_fire;
  logic w_rx_timeout;

  assign w_rx_fire = rx_data_valid && r_rx_ready;
  assign w_tx_fire = r_tx_valid && tx_data_ready;

`ifdef UART_WB_BRIDGE_RX_TIMEOUT_EN
  localparam int unsigned RX_CNT_W = $clog2(RX_TIMEOUT_CYCLES + 1);

  logic [RX_CNT_W-1:0] r_rx_cnt;
  logic                w_rx_wait;

  assign w_rx_wait    = ((r_state == S_ADDR) || (r_state == S_DATA)) && !w_rx_fire;
  assign w_rx_timeout = w_rx_wait && (r_rx_cnt == RX_CNT_W'(RX_TIMEOUT_CYCLES - 1));

  // Idle-gap counter between command bytes; cleared by any accepted byte or outside ADDR/DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt <= '0;
    end else if (w_rx_wait && !w_rx_timeout) begin
      r_rx_cnt <= r_rx_cnt + RX_CNT_W'(1);
    end else begin
      r_rx_cnt <= '0;
    end
  end
`else
  // Partial commands wait forever; the parameter has no effect in this build.
  assign w_rx_timeout = 1'b0 && (RX_TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wb_cnt   <= '0;
      r_err      <= 1'b0;
      r_cyc      <= 1'b0;
      r_rx_ready <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_rx_fire && ((rx_data == CMD_READ) || (rx_data == CMD_WRITE))) begin
            r_we    <= (rx_data == CMD_WRITE);
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= {r_addr[23:0], rx_data};
            r_idx  <= r_idx + 3'd1;
            if (r_idx == 3'd3) begin
              r_idx <= '0;
              if (r_we) begin
                r_state <= S_DATA;
              end else begin
                r_cyc      <= 1'b1;
                r_rx_ready <= 1'b0;
                r_wb_cnt   <= '0;
                r_state    <= S_WB;
              end
            end
          end else if (w_rx_timeout) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_DATA: begin
          if (w_rx_fire) begin
            r_wdata <= {r_wdata[23:0], rx_data};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd3) begin
              r_idx      <= '0;
              r_cyc      <= 1'b1;
              r_rx_ready <= 1'b0;
              r_wb_cnt   <= '0;
              r_state    <= S_WB;
            end
          end else if (w_rx_timeout) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        // An ack in the final timeout cycle still wins over the abort.
        S_WB: begin
          if (wb_ack_i) begin
            r_cyc      <= 1'b0;
            r_idx      <= '0;
            r_tx_valid <= 1'b1;
            if (r_we) begin
              r_tx_data <= RSP_OK;
            end else begin
              r_rdata   <= wb_data_i;
              r_tx_data <= wb_data_i[31:24];
            end
            r_state <= S_RESP;
          end else if (r_wb_cnt == WB_CNT_W'(WB_TIMEOUT_CYCLES - 1)) begin
            r_cyc      <= 1'b0;
            r_err      <= 1'b1;
            r_idx      <= '0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= RSP_ERR;
            r_state    <= S_RESP;
          end else begin
            r_wb_cnt <= r_wb_cnt + WB_CNT_W'(1);
          end
        end

        S_RESP: begin
          if (w_tx_fire) begin
            if (r_err || r_we || (r_idx == 3'd3)) begin
              r_tx_valid <= 1'b0;
              r_err      <= 1'b0;
              r_idx      <= '0;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= r_idx + 3'd1;
              r_rdata   <= {r_rdata[23:0], 8'h00};
              r_tx_data <= r_rdata[23:16];
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data_ready = r_rx_ready;
  assign tx_data       = r_tx_data;
  assign tx_data_valid = r_tx_valid;
  assign wb_addr_o     = r_addr;
  assign wb_we_o       = r_we;
  assign wb_data_o     = r_wdata;
  assign wb_cyc_o      = r_cyc;
  assign wb_stb_o      = r_cyc;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Randomized scoreboard bench for uart_wb_bridge: expected bus cycles and reply bytes are queued at issue time.
module tb_uart_wb_bridge;

  localparam int unsigned WB_TO = 16;
  localparam int unsigned RX_TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [31:0] wb_addr_o;
  logic        wb_we_o;
  logic [31:0] wb_data_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        busy_o;

  always #5 clk = ~clk;

  uart_wb_bridge #(
    .WB_TIMEOUT_CYCLES(WB_TO),
    .RX_TIMEOUT_CYCLES(RX_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .wb_addr_o(wb_addr_o), .wb_we_o(wb_we_o), .wb_data_o(wb_data_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } wb_exp_t;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } tx_exp_t;

  wb_exp_t     wb_q[$];
  tx_exp_t     tx_q[$];
  int          plan_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  logic [31:0] last_wdata = 32'h0;
  bit          bp_mode = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // Content of a never-written slave location.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    rx_data = b;
    rx_data_valid = 1'b1;
    while (!acc && n < 5000) begin
      @(negedge clk);
      acc = rx_data_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_data_valid = 1'b0;
    rx_data = 8'($urandom);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL rx_accept: byte 0x%02h not accepted within 5000 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      cycles($urandom_range(0, 2));
    end
  endtask

  task automatic exp_read(input logic [31:0] a, input int d);
    wb_exp_t     e;
    tx_exp_t     t;
    logic [31:0] v;
    e.addr = a; e.we = 1'b0; e.wdata = last_wdata;
    e.len = (d < 0) ? int'(WB_TO) : d + 1;
    wb_q.push_back(e);
    plan_q.push_back(d);
    if (d < 0) begin
      t.b = 8'h45; t.last = 1'b1;
      tx_q.push_back(t);
    end else begin
      v = model_mem.exists(a) ? model_mem[a] : dflt(a);
      for (int i = 3; i >= 0; i--) begin
        t.b = v[8*i +: 8]; t.last = (i == 0);
        tx_q.push_back(t);
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int d);
    exp_read(a, d);
    send_byte(8'h52);
    cycles($urandom_range(0, 2));
    send_word(a);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input int d);
    wb_exp_t e;
    tx_exp_t t;
    e.addr = a; e.we = 1'b1; e.wdata = wd;
    e.len = (d < 0) ? int'(WB_TO) : d + 1;
    wb_q.push_back(e);
    plan_q.push_back(d);
    last_wdata = wd;
    if (d < 0) begin
      t.b = 8'h45;
    end else begin
      t.b = 8'h4B;
      model_mem[a] = wd;
    end
    t.last = 1'b1;
    tx_q.push_back(t);
    send_byte(8'h57);
    cycles($urandom_range(0, 2));
    send_word(a);
    send_word(wd);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((wb_q.size() != 0 || tx_q.size() != 0 || plan_q.size() != 0 || busy_o) && n < 20000) begin
      cycles(1);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d bus and %0d reply items outstanding", wb_q.size(), tx_q.size());
    end
    cycles(2);
  endtask

  // Wishbone slave: acks after the planned delay, or never for a negative plan.
  initial begin : slave
    bit active;
    int d;
    int cnt;
    active = 1'b0; d = -1; cnt = 0;
    wb_ack_i = 1'b0;
    wb_data_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        active = 1'b0;
        wb_ack_i = 1'b0;
        continue;
      end
      if (wb_cyc_o && !active) begin
        active = 1'b1;
        cnt = 0;
        d = (plan_q.size() != 0) ? plan_q.pop_front() : -1;
      end
      if (!wb_cyc_o) begin
        active = 1'b0;
        wb_ack_i = 1'b0;
        wb_data_i = $urandom;
      end else if (d >= 0 && cnt == d) begin
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          slv_mem[wb_addr_o] = wb_data_o;
          wb_data_i = $urandom;
        end else begin
          wb_data_i = slv_mem.exists(wb_addr_o) ? slv_mem[wb_addr_o] : dflt(wb_addr_o);
        end
        cnt++;
      end else begin
        wb_ack_i = 1'b0;
        wb_data_i = $urandom;
        cnt++;
      end
    end
  end

  // Reply sink: random ready, or 50 stalled cycles per byte in backpressure mode.
  initial begin : sink
    int bc;
    bc = 0;
    tx_data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        if (!tx_data_valid) begin
          tx_data_ready = 1'b0;
        end else if (bc < 50) begin
          tx_data_ready = 1'b0;
          bc++;
        end else begin
          tx_data_ready = 1'b1;
          bc = 0;
        end
      end else begin
        tx_data_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops expectations when the DUT starts a bus cycle or completes a reply byte.
  initial begin : monitor
    logic       prev_cyc, prev_txv, prev_txr;
    logic [7:0] prev_txd;
    wb_exp_t    cur;
    tx_exp_t    t;
    bit         cur_ok, busy_chk;
    int         len, cyc_n, last_acc;
    prev_cyc = 1'b0; prev_txv = 1'b0; prev_txr = 1'b0; prev_txd = 8'h0;
    cur_ok = 1'b0; busy_chk = 1'b0; len = 0; cyc_n = 0; last_acc = -10;
    cur.addr = 32'h0; cur.we = 1'b0; cur.wdata = 32'h0; cur.len = 0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        prev_cyc = 1'b0; prev_txv = 1'b0; busy_chk = 1'b0; cur_ok = 1'b0;
        continue;
      end
      if (busy_chk) begin
        chk("busy_after_reply", 32'(busy_o), 32'(0));
        busy_chk = 1'b0;
      end
      if (wb_cyc_o) begin
        if (!prev_cyc) begin
          len = 0;
          if (wb_q.size() == 0) begin
            chk("wb_unexpected_cycle", 32'(wb_cyc_o), 32'(0));
            cur_ok = 1'b0;
          end else begin
            cur = wb_q.pop_front();
            cur_ok = 1'b1;
            chk("wb_start_latency", 32'(cyc_n), 32'(last_acc + 1));
          end
        end
        len++;
        chk("wb_stb", 32'(wb_stb_o), 32'(1));
        if (cur_ok) begin
          chk("wb_addr", wb_addr_o, cur.addr);
          chk("wb_we", 32'(wb_we_o), 32'(cur.we));
          chk("wb_wdata", wb_data_o, cur.wdata);
        end
      end else if (prev_cyc && cur_ok) begin
        chk("wb_len", 32'(len), 32'(cur.len));
        chk("wb_stb_drop", 32'(wb_stb_o), 32'(0));
        cur_ok = 1'b0;
      end
      prev_cyc = wb_cyc_o;
      if (rx_data_valid && rx_data_ready) last_acc = cyc_n;
      if (prev_txv && !prev_txr) begin
        chk("tx_hold_valid", 32'(tx_data_valid), 32'(1));
        chk("tx_hold_data", 32'(tx_data), 32'(prev_txd));
      end
      if (tx_data_valid && tx_data_ready) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_byte", 32'(tx_data_valid), 32'(0));
        end else begin
          t = tx_q.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(t.b));
          if (t.last) busy_chk = 1'b1;
        end
      end
      prev_txv = tx_data_valid;
      prev_txr = tx_data_ready;
      prev_txd = tx_data;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    logic [7:0]  g;
    int          d;
    rx_data = 8'h0;
    rx_data_valid = 1'b0;
    cycles(3);
    chk("rst_rx_ready", 32'(rx_data_ready), 32'(0));
    chk("rst_tx_valid", 32'(tx_data_valid), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_cyc", 32'(wb_cyc_o), 32'(0));
    chk("rst_stb", 32'(wb_stb_o), 32'(0));
    chk("rst_we", 32'(wb_we_o), 32'(0));
    chk("rst_addr", wb_addr_o, 32'h0);
    chk("rst_wdata", wb_data_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'(0));
    rst_n = 1'b1;
    cycles(2);
    chk("idle_rx_ready", 32'(rx_data_ready), 32'(1));

    do_write(32'h0000_0010, 32'hDEAD_BEEF, 2);
    wait_idle();

    slv_mem[32'h4] = 32'h1234_5678;
    model_mem[32'h4] = 32'h1234_5678;
    do_read(32'h0000_0004, 0);
    wait_idle();

    bp_mode = 1'b1;
    send_byte(8'h00);
    cycles(3);
    send_byte(8'hFF);
    cycles(3);
    do_read(32'h0000_0010, 1);
    wait_idle();
    bp_mode = 1'b0;

    do_read(32'h0000_0020, -1);
    wait_idle();
    do_read(32'h0000_0010, 3);
    wait_idle();

`ifdef UART_WB_BRIDGE_RX_TIMEOUT_EN
    exp_read(32'h0000_0004, 0);
`else
    exp_read(32'h0052_0000, 0);
`endif
    send_byte(8'h52);
    send_byte(8'h00);
    cycles(RX_TO + 10);
    send_byte(8'h52);
    send_word(32'h0000_0004);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        g = 8'($urandom);
        if (g == 8'h52 || g == 8'h57) g = 8'hA0;
        send_byte(g);
      end
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) << 2;
      d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 0) do_write(a, $urandom, d);
      else do_read(a, d);
      cycles($urandom_range(0, 3));
    end
    wait_idle();

    do_read(32'h0000_0030, -1);
    cycles(3);
    chk("pre_reset_cyc", 32'(wb_cyc_o), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(wb_cyc_o), 32'(0));
    chk("async_rst_stb", 32'(wb_stb_o), 32'(0));
    chk("async_rst_tx_valid", 32'(tx_data_valid), 32'(0));
    chk("async_rst_busy", 32'(busy_o), 32'(0));
    tx_q.delete();
    plan_q.delete();
    last_wdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cycles(2);
    chk("post_rst_rx_ready", 32'(rx_data_ready), 32'(1));
    chk("post_rst_busy", 32'(busy_o), 32'(0));
    chk("post_rst_addr", wb_addr_o, 32'h0);
    do_read(32'h0000_0010, 0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
